// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter.
// Owner codes, burst FSM states and the IO select bit.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  localparam int IO_SEL_BIT = 7;

  function automatic int cnt_width(input int lim);
    return (lim < 2) ? 1 : $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating counter shared by the CPU streak and DMA burst beats.
// Up: sat at LIMIT. Down: sat flags the final remaining unit.
module arb_streak_counter
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = 4,
  parameter bit DOWN  = 1'b0,
  localparam int W    = cnt_width(LIMIT)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         sat
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt_q;
  logic         at_top;
  logic         at_one;

  assign at_top = (cnt_q == LIM);
  assign at_one = (cnt_q == W'(1));
  assign sat    = DOWN ? at_one : at_top;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (inc) begin
      if (DOWN && cnt_q != '0)
        cnt_q <= cnt_q - 1'b1;
      else if (!DOWN && !at_top)
        cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/DMA arbiter for the shared data-memory/IO port.
// Define DMEM_ARB_BURST_EN for multi-beat DMA bursts.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_CPU_STREAK = 4,
  parameter int DMA_IO_ALLOW   = 0,
  parameter int BURST_LEN      = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic [31:0] dma_rdata,
  output logic        dma_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  input  logic [31:0] mem_dataout,
  output logic [1:0]  owner
);

  localparam int SW = cnt_width(MAX_CPU_STREAK);

  owner_t gnt;
  owner_t owner_q;
  logic   cpu_g;
  logic   dma_g;
  logic   in_burst;
  logic   dma_blk;
  logic   streak_sat;

  assign dma_blk = (DMA_IO_ALLOW == 0) && dma_addr[IO_SEL_BIT];
  assign cpu_g   = (gnt == OWN_CPU);
  assign dma_g   = (gnt == OWN_DMA);
  assign owner   = owner_q;

  arb_streak_counter #(
    .LIMIT (MAX_CPU_STREAK),
    .DOWN  (1'b0)
  ) u_streak (
    .clock    (clock),
    .reset    (reset),
    .inc      (cpu_g && dma_req),
    .clr      (dma_g || !dma_req),
    .load     (1'b0),
    .load_val ({SW{1'b0}}),
    .sat      (streak_sat)
  );

`ifdef DMEM_ARB_BURST_EN
  localparam int BW = cnt_width(BURST_LEN - 1);

  arb_state_t state_q;
  arb_state_t state_d;
  logic       beat_last;

  arb_streak_counter #(
    .LIMIT (BURST_LEN - 1),
    .DOWN  (1'b1)
  ) u_beat (
    .clock    (clock),
    .reset    (reset),
    .inc      (dma_g && in_burst),
    .clr      (1'b0),
    .load     (dma_g && !in_burst),
    .load_val (BW'(BURST_LEN - 1)),
    .sat      (beat_last)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_ARB;
    else       state_q <= state_d;
  end

  // In BURST a low dma_req is never a granted beat, so it always exits
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ARB:   if (dma_g) state_d = ST_BURST;
      ST_BURST: if (!dma_req || beat_last) state_d = ST_ARB;
    endcase
  end

  assign in_burst = (state_q == ST_BURST);
`else
  assign in_burst = 1'b0;
`endif

  always_comb begin
    gnt = OWN_NONE;
    if (in_burst) begin
      if (dma_req)      gnt = OWN_DMA;
      else if (cpu_req) gnt = OWN_CPU;
    end else if (cpu_req && !(dma_req && streak_sat)) begin
      gnt = OWN_CPU;
    end else if (dma_req) begin
      gnt = OWN_DMA;
    end
  end

  always_comb begin
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_datain = '0;
    cpu_rdata  = '0;
    cpu_stall  = 1'b0;
    dma_gnt    = 1'b0;
    dma_rdata  = '0;
    dma_err    = 1'b0;
    unique case (1'b1)
      cpu_g: begin
        mem_we     = cpu_we;
        mem_addr   = cpu_addr;
        mem_datain = cpu_wdata;
        cpu_rdata  = mem_dataout;
      end
      dma_g: begin
        mem_we     = dma_we && !dma_blk;
        mem_addr   = dma_addr;
        mem_datain = dma_wdata;
        dma_gnt    = 1'b1;
        dma_rdata  = dma_blk ? '0 : mem_dataout;
        dma_err    = dma_blk;
        cpu_stall  = cpu_req;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) owner_q <= OWN_NONE;
    else       owner_q <= gnt;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory/IO port (dram plus memory-mapped switches/LEDs/hex, with addr[7]=1 selecting IO) between two requesters.
- Requester 1 is the pipeline MEM stage. Requester 2 is a DMA/debug loader.
- The CPU has priority. A streak counter guarantees the DMA forward progress, and the CPU is stalled while the DMA owns the port.
- The block sits between the MEM stage and the memory/IO wrapper; its mem_* outputs drive the wrapper's we/addr/datain.

Parameters:
- MAX_CPU_STREAK, 4: consecutive CPU grants allowed while dma_req is pending before the DMA is forced in (legal range 1..15).
- DMA_IO_ALLOW, 0: 1 lets the DMA access the IO space (addr[7]=1); 0 blocks it.
- BURST_LEN, 4: beats per DMA burst (used only with the optional feature; legal range 2..16).

Ports:
- clock in 1: system clock; memory write strobe is qualified by the low phase downstream.
- reset in 1: synchronous, active-high.
- cpu_req in 1: MEM stage performs a load or store this cycle.
- cpu_we in 1: store.
- cpu_addr in 32: byte address.
- cpu_wdata in 32: store data.
- cpu_rdata out 32: load data.
- cpu_stall out 1: freeze the pipeline; MEM stage holds its request.
- dma_req in 1: DMA beat request, held until granted.
- dma_we in 1: DMA write.
- dma_addr in 32: DMA byte address.
- dma_wdata in 32: DMA write data.
- dma_gnt out 1: beat accepted this cycle.
- dma_rdata out 32: read data, valid when dma_gnt=1.
- dma_err out 1: blocked IO access, one-cycle pulse.
- mem_we out 1: to memory wrapper.
- mem_addr out 32: to memory wrapper.
- mem_datain out 32: to memory wrapper.
- mem_dataout in 32: from memory wrapper, combinational with mem_addr.
- owner out 2: registered owner of the previous cycle (0 none, 1 CPU, 2 DMA).

Behaviour:
- Grant is decided combinationally each cycle from the current requests and the registered state. Access latency is 0 cycles: read data returns in the same cycle as the grant.
- Grant rules:
  - If cpu_req and not (dma_req and streak==MAX_CPU_STREAK): grant CPU.
  - Else if dma_req: grant DMA.
  - Else: no grant.
- CPU grant:
  - mem_addr=cpu_addr, mem_datain=cpu_wdata, mem_we=cpu_we.
  - cpu_rdata=mem_dataout.
  - cpu_stall=0.
- DMA grant:
  - mem_* are driven from the dma_* inputs; dma_gnt=1; dma_rdata=mem_dataout.
  - cpu_stall=cpu_req.
  - If DMA_IO_ALLOW=0 and dma_addr[7]=1: mem_we forced to 0, dma_rdata=0, dma_err=1. The beat is still granted, so the DMA does not hang.
- No grant: mem_we=0, mem_addr=0, mem_datain=0.
- Outputs not selected by the grant are 0: cpu_rdata when CPU not granted, dma_rdata when DMA not granted.
- Streak counter (registered):
  - Increments on a CPU grant while dma_req=1; saturates at MAX_CPU_STREAK.
  - Clears on any DMA grant or any cycle with dma_req=0.
  - With MAX_CPU_STREAK=1, CPU and DMA alternate under contention.
- owner register: loaded every cycle with the current grant code.
- Simultaneous requests with streak<MAX: CPU wins; the DMA waits with dma_gnt=0.
- Reset: streak=0, owner=0, burst state cleared. All outputs are combinational from these and the inputs, so with reset high and requests present arbitration still follows the rules with streak=0. Asserting reset mid-burst aborts the burst; the next cycle starts in normal arbitration.

Optional Feature:
- Macro: DMEM_ARB_BURST_EN.
- With the macro defined:
  - A DMA grant from normal arbitration starts a burst: FSM ARB -> BURST, with beat counter = BURST_LEN-1.
  - In BURST, the DMA is granted every cycle dma_req=1, regardless of cpu_req (cpu_stall=cpu_req). The counter decrements per granted beat.
  - The FSM returns to ARB when the counter reaches 0 on a granted beat, or when dma_req drops. Dropping dma_req ends the burst that cycle and the CPU is granted the same cycle.
  - Streak stays 0 throughout a burst.
- Without the macro: single-beat arbitration only; no BURST state or beat counter is synthesized.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - owner codes OWN_NONE/OWN_CPU/OWN_DMA;
  - FSM state encodings ST_ARB/ST_BURST;
  - IO_SEL_BIT=7.
- One sub-module, arb_streak_counter: saturating counter with inc/clr/sat outputs, parameterised by its limit. Used for the streak and reused (as a down-counter variant) for burst beats.

Test Plan:
- CPU only, store 0xDEADBEEF at 0x00000010, then load 0x10 -> mem_we=1 on the store cycle; cpu_rdata=0xDEADBEEF on the load; cpu_stall=0 throughout; owner=1.
- dma_req and cpu_req both held high, MAX_CPU_STREAK=4 -> grant pattern CPU,CPU,CPU,CPU,DMA repeating; cpu_stall=1 exactly on the DMA cycles.
- DMA write to 0x00000080 (IO) with DMA_IO_ALLOW=0 -> dma_gnt=1, dma_err=1, mem_we=0, dma_rdata=0. With DMA_IO_ALLOW=1 -> mem_we=1, dma_err=0.
- DMA read of 0x00000004 with cpu_req=0 -> granted the same cycle; dma_rdata=mem_dataout; streak stays 0.
- DMEM_ARB_BURST_EN, BURST_LEN=4, cpu_req constantly 1, dma_req high for 6 cycles from streak saturation -> 4 consecutive DMA beats, then CPU grants; dma_req dropped after beat 2 -> CPU granted in that same cycle.
- Reset asserted mid-burst or at streak=3 -> next cycle owner=0, streak=0, CPU wins against simultaneous requests.
